// File: rtl/spu_gbuf_resp_pkg.sv
// Shared defaults and helpers for the SPU global-buffer responder.
package spu_gbuf_resp_pkg;

    localparam int unsigned GBUF_ADDR_WIDTH = 12;
    localparam int unsigned GBUF_DATA_WIDTH = 32;
    localparam int unsigned GBUF_DEPTH      = 2048;
    localparam int unsigned GBUF_RLATENCY   = 1;
    localparam int unsigned GBUF_RSP_DEPTH  = 4;

    // True when a word address falls outside the implemented array.
    function automatic logic addr_oor(input logic [31:0] addr, input int unsigned depth);
        return addr >= depth;
    endfunction

endpackage

// File: rtl/spu_gbuf_rsp_fifo.sv
// First-word fall-through response FIFO for host reads of the global buffer.
module spu_gbuf_rsp_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             core_clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; the pointers define which entries are live.
    always_ff @(posedge core_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/spu_gbuf_resp.sv
// Global-buffer responder: engine read/write ports with absolute priority plus a
// credit-limited host port whose read data returns through a FWFT FIFO.
module spu_gbuf_resp
    import spu_gbuf_resp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = GBUF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = GBUF_DATA_WIDTH,
    parameter int unsigned DEPTH      = GBUF_DEPTH,
    parameter int unsigned RLATENCY   = GBUF_RLATENCY,
    parameter int unsigned RSP_DEPTH  = GBUF_RSP_DEPTH
) (
    input  logic                  core_clk,
    input  logic                  rst,
    input  logic                  spu_gbuf_ren,
    input  logic [ADDR_WIDTH-1:0] spu_gbuf_raddr,
    output logic [DATA_WIDTH-1:0] spu_gbuf_rdata,
    input  logic                  spu_gbuf_wen,
    input  logic [ADDR_WIDTH-1:0] spu_gbuf_waddr,
    input  logic [DATA_WIDTH-1:0] spu_gbuf_wdata,
    input  logic                  hst_req_valid,
    output logic                  hst_req_ready,
    input  logic                  hst_req_we,
    input  logic [ADDR_WIDTH-1:0] hst_req_addr,
    input  logic [DATA_WIDTH-1:0] hst_req_wdata,
    output logic                  hst_rsp_valid,
    input  logic                  hst_rsp_ready,
    output logic [DATA_WIDTH-1:0] hst_rsp_rdata,
    output logic                  oor_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  rd_oor_q;
    logic [RLATENCY-1:0]   eng_v_q;
    logic [RLATENCY-1:0]   hst_v_q;
    logic [RLATENCY:0]     eng_v_d;
    logic [RLATENCY:0]     hst_v_d;
    logic [CNT_W-1:0]      inflight_q;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] eng_hold_q;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [DATA_WIDTH-1:0] last_data;
    logic                  rsp_push;
    logic                  rsp_pop;

    logic                  eng_roor;
    logic                  eng_woor;
    logic                  hst_oor;
    logic                  credit_ok;
    logic                  hst_rd_acc;
    logic                  hst_wr_acc;
    logic                  rd_en;
    logic                  rd_oor;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    // Arbitration: engine wins outright; host reads also need a free response credit.
    always_comb begin
        eng_roor      = addr_oor(32'(spu_gbuf_raddr), DEPTH);
        eng_woor      = addr_oor(32'(spu_gbuf_waddr), DEPTH);
        hst_oor       = addr_oor(32'(hst_req_addr), DEPTH);
        credit_ok     = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CNT_W + 1)'(RSP_DEPTH);
        hst_req_ready = hst_req_we ? !spu_gbuf_wen : (!spu_gbuf_ren && credit_ok);
        hst_rd_acc    = hst_req_valid && hst_req_ready && !hst_req_we;
        hst_wr_acc    = hst_req_valid && hst_req_ready && hst_req_we;
        rd_en         = spu_gbuf_ren || hst_rd_acc;
        rd_addr       = spu_gbuf_ren ? spu_gbuf_raddr : hst_req_addr;
        rd_oor        = spu_gbuf_ren ? eng_roor : hst_oor;
        wr_en         = (spu_gbuf_wen && !eng_woor) || (hst_wr_acc && !hst_oor);
        wr_addr       = spu_gbuf_wen ? spu_gbuf_waddr : hst_req_addr;
        wr_data       = spu_gbuf_wen ? spu_gbuf_wdata : hst_req_wdata;
    end

    // 1R1W array with registered read; non-blocking update gives read-first behaviour.
    always_ff @(posedge core_clk) begin
        if (wr_en) mem[wr_addr[IDX_W-1:0]] <= wr_data;
        if (rd_en) rd_q <= mem[rd_addr[IDX_W-1:0]];
    end

    assign eng_v_d = {eng_v_q, spu_gbuf_ren};
    assign hst_v_d = {hst_v_q, hst_rd_acc};
    assign rsp_push = hst_v_q[RLATENCY-1];

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            rd_oor_q   <= 1'b0;
            eng_v_q    <= '0;
            hst_v_q    <= '0;
            inflight_q <= '0;
            oor_err    <= 1'b0;
            eng_hold_q <= '0;
        end else begin
            if (rd_en) rd_oor_q <= rd_oor;
            eng_v_q    <= eng_v_d[RLATENCY-1:0];
            hst_v_q    <= hst_v_d[RLATENCY-1:0];
            eng_hold_q <= spu_gbuf_rdata;
            case ({hst_rd_acc, rsp_push})
                2'b10:   inflight_q <= inflight_q + CNT_W'(1);
                2'b01:   inflight_q <= inflight_q - CNT_W'(1);
                default: inflight_q <= inflight_q;
            endcase
            if ((spu_gbuf_ren && eng_roor) || (spu_gbuf_wen && eng_woor) ||
                ((hst_rd_acc || hst_wr_acc) && hst_oor))
                oor_err <= 1'b1;
        end
    end

    assign s1_data = rd_oor_q ? '0 : rd_q;

    // Extra read-data stages shared by engine and host reads, tagged by the valid pipes.
    if (RLATENCY > 1) begin : g_pipe
        logic [RLATENCY-2:0][DATA_WIDTH-1:0] dq_q;
        logic [RLATENCY-1:0][DATA_WIDTH-1:0] dq_d;
        assign dq_d = {dq_q, s1_data};
        always_ff @(posedge core_clk or posedge rst) begin
            if (rst) dq_q <= '0;
            else     dq_q <= dq_d[RLATENCY-2:0];
        end
        assign last_data = dq_q[RLATENCY-2];
    end else begin : g_nopipe
        assign last_data = s1_data;
    end

    assign spu_gbuf_rdata = eng_v_q[RLATENCY-1] ? last_data : eng_hold_q;

    spu_gbuf_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .core_clk  (core_clk),
        .rst       (rst),
        .push      (rsp_push),
        .push_data (last_data),
        .pop       (rsp_pop),
        .pop_data  (hst_rsp_rdata),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign hst_rsp_valid = !fifo_empty;
    assign rsp_pop       = hst_rsp_valid && hst_rsp_ready;

endmodule

// File: tb/tb_spu_gbuf_resp.sv
// Randomised and directed bench for spu_gbuf_resp against a transaction-level model.
module tb_spu_gbuf_resp;

    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2048;
    localparam int unsigned RLAT  = 3;
    localparam int unsigned RSPD  = 6;

    logic          core_clk;
    logic          rst;
    logic          spu_gbuf_ren;
    logic [AW-1:0] spu_gbuf_raddr;
    logic [DW-1:0] spu_gbuf_rdata;
    logic          spu_gbuf_wen;
    logic [AW-1:0] spu_gbuf_waddr;
    logic [DW-1:0] spu_gbuf_wdata;
    logic          hst_req_valid;
    logic          hst_req_ready;
    logic          hst_req_we;
    logic [AW-1:0] hst_req_addr;
    logic [DW-1:0] hst_req_wdata;
    logic          hst_rsp_valid;
    logic          hst_rsp_ready;
    logic [DW-1:0] hst_rsp_rdata;
    logic          oor_err;

    spu_gbuf_resp #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .RLATENCY   (RLAT),
        .RSP_DEPTH  (RSPD)
    ) dut (
        .core_clk       (core_clk),
        .rst            (rst),
        .spu_gbuf_ren   (spu_gbuf_ren),
        .spu_gbuf_raddr (spu_gbuf_raddr),
        .spu_gbuf_rdata (spu_gbuf_rdata),
        .spu_gbuf_wen   (spu_gbuf_wen),
        .spu_gbuf_waddr (spu_gbuf_waddr),
        .spu_gbuf_wdata (spu_gbuf_wdata),
        .hst_req_valid  (hst_req_valid),
        .hst_req_ready  (hst_req_ready),
        .hst_req_we     (hst_req_we),
        .hst_req_addr   (hst_req_addr),
        .hst_req_wdata  (hst_req_wdata),
        .hst_rsp_valid  (hst_rsp_valid),
        .hst_rsp_ready  (hst_rsp_ready),
        .hst_rsp_rdata  (hst_rsp_rdata),
        .oor_err        (oor_err)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    // Reference model: word array, timestamped pending reads, response queue.
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } pend_t;

    logic [DW-1:0] mem_m [DEPTH];
    pend_t         eng_pend[$];
    pend_t         hst_pend[$];
    logic [DW-1:0] rsp_q[$];
    logic [DW-1:0] eng_exp;
    bit            oor_m;
    bit            acc;
    int            edge_n;
    int            n_cmp;
    int            n_err;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit is_oor(input logic [AW-1:0] a);
        return int'(a) >= int'(DEPTH);
    endfunction

    function automatic logic [DW-1:0] rd_m(input logic [AW-1:0] a);
        if (is_oor(a)) return '0;
        return mem_m[int'(a)];
    endfunction

    function automatic bit exp_ready();
        bit credit;
        credit = (hst_pend.size() + rsp_q.size()) < int'(RSPD);
        return hst_req_we ? !spu_gbuf_wen : (!spu_gbuf_ren && credit);
    endfunction

    task automatic model_edge();
        pend_t p;
        edge_n++;
        if (rsp_q.size() > 0 && hst_rsp_ready) void'(rsp_q.pop_front());
        while (hst_pend.size() > 0 && hst_pend[0].due <= edge_n) begin
            p = hst_pend.pop_front();
            rsp_q.push_back(p.data);
        end
        if (spu_gbuf_ren) eng_pend.push_back('{edge_n + int'(RLAT) - 1, rd_m(spu_gbuf_raddr)});
        while (eng_pend.size() > 0 && eng_pend[0].due <= edge_n) begin
            p = eng_pend.pop_front();
            eng_exp = p.data;
        end
        if (acc && !hst_req_we) hst_pend.push_back('{edge_n + int'(RLAT), rd_m(hst_req_addr)});
        if ((spu_gbuf_ren && is_oor(spu_gbuf_raddr)) || (spu_gbuf_wen && is_oor(spu_gbuf_waddr)) ||
            (acc && is_oor(hst_req_addr)))
            oor_m = 1'b1;
        if (spu_gbuf_wen && !is_oor(spu_gbuf_waddr)) mem_m[int'(spu_gbuf_waddr)] = spu_gbuf_wdata;
        if (acc && hst_req_we && !is_oor(hst_req_addr)) mem_m[int'(hst_req_addr)] = hst_req_wdata;
    endtask

    // One clock: check outputs against the model, then advance the model at the edge.
    task automatic cycle();
        #1;
        acc = hst_req_valid && exp_ready();
        if (hst_req_valid) check("req_ready", hst_req_ready, exp_ready());
        check("rsp_valid", hst_rsp_valid, rsp_q.size() > 0);
        if (rsp_q.size() > 0) check("rsp_rdata", hst_rsp_rdata, rsp_q[0]);
        check("eng_rdata", spu_gbuf_rdata, eng_exp);
        check("oor_err", oor_err, oor_m);
        @(posedge core_clk);
        model_edge();
        @(negedge core_clk);
    endtask

    task automatic idle();
        spu_gbuf_ren   = 1'b0;
        spu_gbuf_raddr = '0;
        spu_gbuf_wen   = 1'b0;
        spu_gbuf_waddr = '0;
        spu_gbuf_wdata = '0;
        hst_req_valid  = 1'b0;
        hst_req_we     = 1'b0;
        hst_req_addr   = '0;
        hst_req_wdata  = '0;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_rsp_valid", hst_rsp_valid, 0);
        check("rst_eng_rdata", spu_gbuf_rdata, 0);
        check("rst_oor_err", oor_err, 0);
        idle();
        @(negedge core_clk);
        @(negedge core_clk);
        eng_pend.delete();
        hst_pend.delete();
        rsp_q.delete();
        eng_exp = '0;
        oor_m   = 1'b0;
        acc     = 1'b0;
        rst     = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int unsigned sel;
        sel = $urandom_range(0, 15);
        if (sel == 0) return AW'($urandom_range(DEPTH, (1 << AW) - 1));
        if (sel < 6)  return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        int n_acc;
        n_cmp   = 0;
        n_err   = 0;
        edge_n  = 0;
        eng_exp = '0;
        oor_m   = 1'b0;
        acc     = 1'b0;
        rst     = 1'b1;
        hst_rsp_ready = 1'b0;
        idle();
        repeat (3) @(negedge core_clk);
        rst = 1'b0;
        cycle();

        // Preload the whole array so every later read has a known value.
        for (int a = 0; a < int'(DEPTH); a++) begin
            spu_gbuf_wen   = 1'b1;
            spu_gbuf_waddr = AW'(a);
            spu_gbuf_wdata = $urandom;
            cycle();
        end
        idle();
        cycle();

        // Engine write then read back.
        spu_gbuf_wen = 1'b1; spu_gbuf_waddr = 12'h010; spu_gbuf_wdata = 32'hA5A5_0001;
        cycle();
        idle();
        spu_gbuf_ren = 1'b1; spu_gbuf_raddr = 12'h010;
        cycle();
        idle();
        repeat (RLAT - 1) cycle();
        #1 check("wr_rd_0x010", spu_gbuf_rdata, 32'hA5A5_0001);

        // Read-first on a same-address collision.
        spu_gbuf_wen = 1'b1; spu_gbuf_waddr = 12'h020; spu_gbuf_wdata = 32'h1111;
        cycle();
        spu_gbuf_ren = 1'b1; spu_gbuf_raddr = 12'h020; spu_gbuf_wdata = 32'h2222;
        cycle();
        spu_gbuf_wen = 1'b0;
        cycle();
        idle();
        repeat (RLAT - 2) cycle();
        #1 check("collide_old", spu_gbuf_rdata, 32'h1111);
        cycle();
        #1 check("collide_new", spu_gbuf_rdata, 32'h2222);

        // Host read starved by 64 cycles of engine reads.
        hst_rsp_ready = 1'b1;
        hst_req_valid = 1'b1; hst_req_we = 1'b0; hst_req_addr = 12'h020;
        spu_gbuf_ren  = 1'b1; spu_gbuf_raddr = 12'h010;
        repeat (64) cycle();
        spu_gbuf_ren = 1'b0;
        #1 check("starve_accept", hst_req_ready, 1);
        cycle();
        idle();
        repeat (RLAT) cycle();
        #1 check("starve_rsp_valid", hst_rsp_valid, 1);
        check("starve_rsp_data", hst_rsp_rdata, 32'h2222);
        repeat (4) cycle();

        // Credit limit with a stalled response port, then in-order drain.
        hst_rsp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < int'(RSPD) + 8; i++) begin
            hst_req_valid = 1'b1; hst_req_we = 1'b0;
            hst_req_addr  = AW'(32'h100 + n_acc);
            #1 if (hst_req_ready) n_acc++;
            cycle();
        end
        check("credit_accepts", 64'(n_acc), 64'(RSPD));
        #1 check("credit_ready_low", hst_req_ready, 0);
        idle();
        hst_rsp_ready = 1'b1;
        repeat (RSPD + 2) cycle();
        #1 check("credit_drained", hst_rsp_valid, 0);

        // Out-of-range host read, then out-of-range host write.
        hst_req_valid = 1'b1; hst_req_we = 1'b0; hst_req_addr = 12'd2048;
        cycle();
        idle();
        repeat (RLAT) cycle();
        #1 check("oor_rd_valid", hst_rsp_valid, 1);
        check("oor_rd_data", hst_rsp_rdata, 0);
        check("oor_rd_flag", oor_err, 1);
        cycle();
        hst_req_valid = 1'b1; hst_req_we = 1'b1; hst_req_addr = 12'd2050; hst_req_wdata = 32'hDEAD_BEEF;
        cycle();
        idle();
        spu_gbuf_ren = 1'b1; spu_gbuf_raddr = 12'd2;
        cycle();
        idle();
        repeat (RLAT) cycle();
        check("oor_wr_flag", oor_err, 1);

        // Reset with three reads in flight and two responses queued.
        hst_rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            hst_req_valid = 1'b1; hst_req_we = 1'b0; hst_req_addr = AW'(32'h010 + 16 * i);
            cycle();
        end
        idle();
        for (int i = 0; i < 10 && rsp_q.size() < 2; i++) cycle();
        for (int i = 0; i < 3; i++) begin
            hst_req_valid = 1'b1; hst_req_we = 1'b0; hst_req_addr = AW'(32'h200 + i);
            cycle();
        end
        do_reset();
        hst_rsp_ready = 1'b1;
        repeat (10) cycle();
        spu_gbuf_ren = 1'b1; spu_gbuf_raddr = 12'h010;
        cycle();
        spu_gbuf_ren = 1'b0;
        hst_req_valid = 1'b1; hst_req_we = 1'b0; hst_req_addr = 12'h020;
        cycle();
        idle();
        #1 check("post_rst_eng", spu_gbuf_rdata, 0);
        repeat (RLAT + 2) cycle();
        check("post_rst_keep", spu_gbuf_rdata, 32'hA5A5_0001);

        // Randomised traffic with one mid-run reset.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            spu_gbuf_ren   = ($urandom_range(0, 3) == 0);
            spu_gbuf_raddr = rand_addr();
            spu_gbuf_wen   = ($urandom_range(0, 3) == 0);
            spu_gbuf_waddr = rand_addr();
            spu_gbuf_wdata = $urandom;
            hst_rsp_ready  = ($urandom_range(0, 3) != 0);
            if (!hst_req_valid || acc) begin
                hst_req_valid = ($urandom_range(0, 2) != 0);
                hst_req_we    = ($urandom_range(0, 1) == 1);
                hst_req_addr  = rand_addr();
                hst_req_wdata = $urandom;
            end
            cycle();
        end
        idle();
        hst_rsp_ready = 1'b1;
        repeat (RSPD + RLAT + 2) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
